calc_sequencer: RTL and testbench

//  Registered operation sequencer for the primitive calculator. Captures operands A/B and

---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_sequencer_if.sv | 37 +++
 rtl/calc_sequencer_cycle_timer.sv | 30 +++
 rtl/calc_sequencer.sv | 134 +++++++++++++
 tb/tb_calc_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM state encoding, opcodes,
// display constants and default widths.
`default_nettype none

package calc_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int OP_W_DEF    = 3;
   localparam int NUM_OPS_DEF = 5;
   localparam int TIMEOUT_DEF = 255;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;

   localparam logic [3:0] ERR_NIBBLE = 4'hE;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_A  = 3'd1,
      ST_LOAD_B  = 3'd2,
      ST_LOAD_OP = 3'd3,
      ST_ISSUE   = 3'd4,
      ST_WAIT    = 3'd5,
      ST_SHOW    = 3'd6,
      ST_ERROR   = 3'd7
   } state_t;

endpackage

`default_nettype wire

// File: rtl/calc_sequencer_if.sv
// Bundles the user-input, ALU handshake and display signals of the sequencer.
`default_nettype none

interface calc_sequencer_if import calc_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF
);
   logic              select_pulse;
   logic              restart;
   logic [DATA_W-1:0] rotary_value;
   logic [DATA_W-1:0] alu_result;
   logic              alu_flag;
   logic              alu_done;
   logic              alu_start;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic              disp_load;
   logic [3:0]        disp_tens;
   logic [3:0]        disp_units;
   logic              led_flag;
   logic              busy;

   modport master (
      input  select_pulse, restart, rotary_value, alu_result, alu_flag, alu_done,
      output alu_start, alu_a, alu_b, alu_op, disp_load, disp_tens, disp_units,
             led_flag, busy
   );

   modport slave (
      output select_pulse, restart, rotary_value, alu_result, alu_flag, alu_done,
      input  alu_start, alu_a, alu_b, alu_op, disp_load, disp_tens, disp_units,
             led_flag, busy
   );
endinterface

`default_nettype wire

// File: rtl/calc_sequencer_cycle_timer.sv
// Clear/enable cycle counter that saturates at its terminal count TIMEOUT-1.
`default_nettype none

module cycle_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   assign terminal = (count >= CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !terminal) begin
         count <= count + CNT_W'(1);
      end
   end
endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// Operation sequencer: captures A, B and opcode from the rotary value, runs one ALU
// operation via start/done and drives the two-digit display and LED.
`default_nettype none

module calc_sequencer import calc_pkg::*; #(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int OP_W    = OP_W_DEF,
   parameter int NUM_OPS = NUM_OPS_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   calc_sequencer_if.master bus
);
   state_t            state;
   state_t            next_state;
   logic              op_valid;
   logic              timer_run;
   logic              timer_tc;
   logic              alu_start_reg;
   logic              busy_reg;
   logic              disp_load_reg;
   logic              led_reg;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [OP_W-1:0]   op_reg;
   logic [7:0]        disp_reg;

   assign op_valid  = (bus.rotary_value < DATA_W'(NUM_OPS));
   // The ISSUE cycle counts toward the wait budget.
   assign timer_run = (state == ST_ISSUE) || (state == ST_WAIT);

   cycle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (!timer_run),
      .enable   (timer_run),
      .terminal (timer_tc)
   );

   always_comb begin
      next_state = ST_IDLE;
      case (state)
         ST_IDLE:    next_state = bus.select_pulse ? ST_LOAD_A : ST_IDLE;
         ST_LOAD_A:  next_state = bus.select_pulse ? ST_LOAD_B : ST_LOAD_A;
         ST_LOAD_B:  next_state = bus.select_pulse ? ST_LOAD_OP : ST_LOAD_B;
         ST_LOAD_OP: next_state = (bus.select_pulse && op_valid) ? ST_ISSUE : ST_LOAD_OP;
         ST_ISSUE:   next_state = ST_WAIT;
         ST_WAIT:    next_state = bus.alu_done ? ST_SHOW : (timer_tc ? ST_ERROR : ST_WAIT);
         ST_SHOW:    next_state = bus.select_pulse ? ST_IDLE : ST_SHOW;
         ST_ERROR:   next_state = bus.select_pulse ? ST_IDLE : ST_ERROR;
         default:    next_state = ST_IDLE;
      endcase
      if (bus.restart) begin
         next_state = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         alu_start_reg <= 1'b0;
         busy_reg      <= 1'b0;
         disp_load_reg <= 1'b0;
         led_reg       <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         op_reg        <= '0;
         disp_reg      <= '0;
      end else begin
         state         <= next_state;
         alu_start_reg <= (next_state == ST_ISSUE);
         busy_reg      <= (next_state == ST_ISSUE) || (next_state == ST_WAIT);
         disp_load_reg <= (next_state != ST_IDLE);

         if (bus.restart) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
         end else begin
            if (state == ST_LOAD_A && next_state == ST_LOAD_B) begin
               a_reg <= bus.rotary_value;
            end
            if (state == ST_LOAD_B && next_state == ST_LOAD_OP) begin
               b_reg <= bus.rotary_value;
            end
            if (state == ST_LOAD_OP && next_state == ST_ISSUE) begin
               op_reg <= bus.rotary_value[OP_W-1:0];
            end
         end

         // Display and LED follow the state being entered; ISSUE/WAIT hold them.
         case (next_state)
            ST_IDLE: begin
               disp_reg <= '0;
               led_reg  <= 1'b0;
            end
            ST_LOAD_A, ST_LOAD_B: begin
               disp_reg <= 8'(bus.rotary_value);
            end
            ST_LOAD_OP: begin
               disp_reg <= 8'(bus.rotary_value[OP_W-1:0]);
            end
            ST_SHOW: begin
               if (state == ST_WAIT) begin
                  disp_reg <= 8'(bus.alu_result);
                  led_reg  <= bus.alu_flag;
               end
            end
            ST_ERROR: begin
               disp_reg <= {ERR_NIBBLE, ERR_NIBBLE};
               led_reg  <= 1'b1;
            end
            default: begin
               disp_reg <= disp_reg;
            end
         endcase
      end
   end

   assign bus.alu_start  = alu_start_reg;
   assign bus.busy       = busy_reg;
   assign bus.disp_load  = disp_load_reg;
   assign bus.led_flag   = led_reg;
   assign bus.alu_a      = a_reg;
   assign bus.alu_b      = b_reg;
   assign bus.alu_op     = op_reg;
   assign bus.disp_tens  = disp_reg[7:4];
   assign bus.disp_units = disp_reg[3:0];
endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// Randomized self-checking bench for calc_sequencer with an arithmetic ALU reference model.
`default_nettype none

module tb_calc_sequencer;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   calc_sequencer_if #(.DATA_W(8), .OP_W(3)) bus ();

   calc_sequencer #(
      .DATA_W  (8),
      .OP_W    (3),
      .NUM_OPS (5),
      .TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU: {flag, result}; flag is carry, borrow or zero depending on opcode.
   function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
      logic [8:0] r;
      r = 9'd0;
      case (op)
         3'd0: r = {1'b0, a} + {1'b0, b};
         3'd1: r = {1'b0, a} - {1'b0, b};
         3'd2: r = {(a & b) == 8'd0, a & b};
         3'd3: r = {(a | b) == 8'd0, a | b};
         3'd4: r = {(a ^ b) == 8'd0, a ^ b};
         default: r = 9'd0;
      endcase
      return r;
   endfunction

   assign {bus.alu_flag, bus.alu_result} = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

   logic [7:0] disp;
   assign disp = {bus.disp_tens, bus.disp_units};

   function automatic logic [30:0] outs();
      return {bus.alu_start, bus.busy, bus.disp_load, bus.led_flag, bus.disp_tens,
              bus.disp_units, bus.alu_a, bus.alu_b, bus.alu_op};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] v);
      bus.rotary_value = v;
      bus.select_pulse = 1'b1;
      tick();
      bus.select_pulse = 1'b0;
      tick();
   endtask

   // From IDLE: walk through the load states; returns one step after entering ISSUE.
   task automatic issue_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      press(8'h00);
      press(a);
      press(b);
      bus.rotary_value = {5'd0, op};
      bus.select_pulse = 1'b1;
      tick();
      bus.select_pulse = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (outs() !== 31'd0) begin n_fail++; $display("FAIL reset_async: got %h want 0", outs()); end
      tick(); tick();
      rst = 1'b0;
      tick();
      n_cmp++; if (outs() !== 31'd0) begin n_fail++; $display("FAIL reset_idle: got %h want 0", outs()); end
   endtask

   task automatic test_basic();
      bus.alu_done = 1'b1;
      press(8'h00);
      n_cmp++; if (bus.disp_load !== 1'b1) begin n_fail++; $display("FAIL basic_load_a_disp: got %b want 1", bus.disp_load); end
      bus.rotary_value = 8'h12;
      tick();
      n_cmp++; if (disp !== 8'h12) begin n_fail++; $display("FAIL basic_track: got %h want 12", disp); end
      bus.select_pulse = 1'b1; tick(); bus.select_pulse = 1'b0;
      n_cmp++; if (bus.alu_a !== 8'h12) begin n_fail++; $display("FAIL basic_a: got %h want 12", bus.alu_a); end
      bus.rotary_value = 8'h34;
      bus.select_pulse = 1'b1; tick(); bus.select_pulse = 1'b0;
      n_cmp++; if (bus.alu_b !== 8'h34) begin n_fail++; $display("FAIL basic_b: got %h want 34", bus.alu_b); end
      n_cmp++; if (disp !== 8'h04) begin n_fail++; $display("FAIL basic_op_disp: got %h want 04", disp); end
      bus.rotary_value = 8'h00;
      bus.select_pulse = 1'b1; tick(); bus.select_pulse = 1'b0;
      n_cmp++; if ({bus.alu_start, bus.busy, bus.alu_op} !== 5'b11_000) begin n_fail++; $display("FAIL basic_issue: got %b want 11000", {bus.alu_start, bus.busy, bus.alu_op}); end
      tick();
      n_cmp++; if ({bus.alu_start, bus.busy} !== 2'b01) begin n_fail++; $display("FAIL basic_wait: got %b want 01", {bus.alu_start, bus.busy}); end
      tick();
      n_cmp++; if ({bus.busy, bus.led_flag, disp} !== {2'b00, 8'h46}) begin n_fail++; $display("FAIL basic_show: got %h want 046", {bus.busy, bus.led_flag, disp}); end
      tick();
      n_cmp++; if ({bus.alu_start, disp} !== {1'b0, 8'h46}) begin n_fail++; $display("FAIL basic_hold: got %h want 046", {bus.alu_start, disp}); end
      press(8'h00);
      n_cmp++; if ({bus.disp_load, bus.led_flag, disp} !== 10'd0) begin n_fail++; $display("FAIL basic_idle: got %h want 0", {bus.disp_load, bus.led_flag, disp}); end
      bus.alu_done = 1'b0;
   endtask

   task automatic test_invalid_op();
      logic [7:0] a, b, bad;
      logic [8:0] e;
      a = 8'($urandom); b = 8'($urandom); bad = 8'($urandom_range(5, 7));
      press(8'h00); press(a); press(b);
      bus.rotary_value = bad;
      bus.select_pulse = 1'b1; tick(); bus.select_pulse = 1'b0;
      n_cmp++; if ({bus.alu_start, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL inv_no_start: got %b want 00", {bus.alu_start, bus.busy}); end
      n_cmp++; if (disp !== bad) begin n_fail++; $display("FAIL inv_disp: got %h want %h", disp, bad); end
      tick();
      bus.rotary_value = 8'd2;
      bus.select_pulse = 1'b1; tick(); bus.select_pulse = 1'b0;
      n_cmp++; if ({bus.alu_start, bus.alu_op} !== 4'b1_010) begin n_fail++; $display("FAIL inv_then_valid: got %b want 1010", {bus.alu_start, bus.alu_op}); end
      e = alu_model(a, b, 3'd2);
      bus.alu_done = 1'b1; tick(); tick(); bus.alu_done = 1'b0;
      n_cmp++; if ({bus.led_flag, disp} !== e) begin n_fail++; $display("FAIL inv_result: got %h want %h", {bus.led_flag, disp}, e); end
      press(8'h00);
   endtask

   task automatic test_timeout();
      int n;
      bus.alu_done = 1'b0;
      issue_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)));
      n = 0;
      while (n < 20 && disp !== 8'hEE) begin
         tick();
         n++;
      end
      n_cmp++; if (n !== TO) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
      n_cmp++; if ({bus.led_flag, bus.disp_load, bus.busy} !== 3'b110) begin n_fail++; $display("FAIL timeout_err: got %b want 110", {bus.led_flag, bus.disp_load, bus.busy}); end
      press(8'h00);
      n_cmp++; if ({bus.led_flag, bus.disp_load, disp} !== 10'd0) begin n_fail++; $display("FAIL timeout_exit: got %h want 0", {bus.led_flag, bus.disp_load, disp}); end
   endtask

   task automatic test_restart_wait();
      bus.alu_done = 1'b0;
      issue_op(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 3'($urandom_range(1, 4)));
      tick(); tick();
      bus.restart = 1'b1; bus.alu_done = 1'b1;
      tick();
      bus.restart = 1'b0; bus.alu_done = 1'b0;
      n_cmp++; if (outs() !== 31'd0) begin n_fail++; $display("FAIL restart_wait: got %h want 0", outs()); end
      bus.alu_done = 1'b1;
      repeat (3) tick();
      bus.alu_done = 1'b0;
      n_cmp++; if ({bus.disp_load, bus.busy, disp} !== 10'd0) begin n_fail++; $display("FAIL stray_done: got %h want 0", {bus.disp_load, bus.busy, disp}); end
   endtask

   task automatic test_select_restart();
      logic [7:0] a;
      a = 8'($urandom_range(1, 255));
      press(8'h00); press(a);
      n_cmp++; if (bus.alu_a !== a) begin n_fail++; $display("FAIL selrst_a: got %h want %h", bus.alu_a, a); end
      bus.rotary_value = 8'($urandom_range(1, 255));
      bus.select_pulse = 1'b1; bus.restart = 1'b1;
      tick();
      bus.select_pulse = 1'b0; bus.restart = 1'b0;
      tick();
      n_cmp++; if ({bus.disp_load, bus.alu_a, bus.alu_b} !== 17'd0) begin n_fail++; $display("FAIL selrst: got %h want 0", {bus.disp_load, bus.alu_a, bus.alu_b}); end
   endtask

   task automatic test_async_reset_and_edge();
      logic [7:0] a, b;
      logic [8:0] e;
      bus.alu_done = 1'b0;
      issue_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)));
      tick(); tick();
      #3 rst = 1'b1;
      #1;
      n_cmp++; if (outs() !== 31'd0) begin n_fail++; $display("FAIL async_rst: got %h want 0", outs()); end
      tick();
      rst = 1'b0;
      bus.alu_done = 1'b1;
      tick(); tick();
      bus.alu_done = 1'b0;
      n_cmp++; if ({bus.disp_load, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL async_rst_idle: got %b want 00", {bus.disp_load, bus.busy}); end
      // Done in the last allowed cycle must win over the timeout.
      a = 8'($urandom_range(0, 127)); b = 8'($urandom_range(0, 127));
      if (a + b == 238) b = b - 8'd1;
      e = alu_model(a, b, 3'd0);
      issue_op(a, b, 3'd0);
      repeat (TO - 1) tick();
      n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL edge_waiting: got %b want 1", bus.busy); end
      bus.alu_done = 1'b1; tick(); bus.alu_done = 1'b0;
      n_cmp++; if ({bus.busy, bus.led_flag, disp} !== {1'b0, e}) begin n_fail++; $display("FAIL edge_done_wins: got %h want %h", {bus.busy, bus.led_flag, disp}, {1'b0, e}); end
      press(8'h00);
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      logic [2:0] op;
      logic [8:0] e;
      int d;
      for (int i = 0; i < 16; i++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 4));
         d = $urandom_range(0, 5);
         e = alu_model(a, b, op);
         bus.alu_done = (d == 0);
         issue_op(a, b, op);
         tick();
         repeat (d) begin
            bus.rotary_value = 8'($urandom);
            tick();
         end
         bus.alu_done = 1'b1; tick(); bus.alu_done = 1'b0;
         n_cmp++; if ({bus.led_flag, disp} !== e) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", i, {bus.led_flag, disp}, e); end
         n_cmp++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {a, b, op}) begin n_fail++; $display("FAIL b2b_operands[%0d]: got %h want %h", i, {bus.alu_a, bus.alu_b, bus.alu_op}, {a, b, op}); end
         bus.select_pulse = 1'b1; tick(); bus.select_pulse = 1'b0;
         n_cmp++; if ({bus.disp_load, bus.led_flag} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %b want 00", i, {bus.disp_load, bus.led_flag}); end
      end
   endtask

   initial begin
      bus.select_pulse = 1'b0;
      bus.restart      = 1'b0;
      bus.rotary_value = 8'h00;
      bus.alu_done     = 1'b0;
      test_reset();
      test_basic();
      test_invalid_op();
      test_timeout();
      test_restart_wait();
      test_select_restart();
      test_async_reset_and_edge();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule

`default_nettype wire
